// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch: PC-driven instruction fetch with a valid/ready memory request,  |
// | a single-pulse response and a held word for decode.                        |
// | Optional: define IFU_MISALIGN_CHK_EN to turn a misaligned PC into a fault. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              pc_stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_fault,
  output logic [PERF_W-1:0] perf_wait_cyc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              kill_q, kill_d;
  logic              fault_q, fault_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              misalign;

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    kill_d    = kill_q;
    fault_d   = fault_q;
    perf_d    = perf_q;
    case (state_q)
      IDLE: begin
        if (pc_valid && !flush) begin
          if (misalign) begin
            state_d   = HOLD;
            inst_d    = NOP_INST;
            inst_pc_d = pc;
            fault_d   = 1'b1;
          end else begin
            state_d  = REQ;
            req_pc_d = pc;
            addr_d   = {pc[31:2], 2'b00};
          end
        end
      end
      REQ: begin
        // A flushed request still has to complete; kill marks its data for discard.
        if (flush) kill_d = 1'b1;
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (perf_q != {PERF_W{1'b1}}) perf_d = perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
        if (imem_rsp_valid) begin
          if (kill_q || flush) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d   = HOLD;
            inst_d    = imem_rsp_data;
            inst_pc_d = req_pc_q;
            fault_d   = 1'b0;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        // flush takes priority over a same-cycle inst_ready: no handoff.
        if (flush || inst_ready) begin
          state_d = IDLE;
          inst_d  = NOP_INST;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_pc_q  <= RESET_PC;
      addr_q    <= 32'h0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
      fault_q   <= 1'b0;
      perf_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      kill_q    <= kill_d;
      fault_q   <= fault_d;
      perf_q    <= perf_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = addr_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = fault_q;
  assign perf_wait_cyc  = perf_q;
  assign pc_stall       = !rst || !(inst_valid && inst_ready && !flush);

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifu_fetch: randomized bench for ifu_fetch against a transaction model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ifu_fetch;

  localparam logic [31:0] C_NOP    = 32'h0000_0013;
  localparam logic [31:0] C_RSTPC  = 32'h8000_0000;
  localparam int          C_PERF_W = 5;
  localparam int          C_PMAX   = (1 << C_PERF_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [31:0]         pc = '0;
  logic                pc_valid = 1'b0;
  logic                flush = 1'b0;
  logic                pc_stall;
  logic                imem_req_valid;
  logic                imem_req_ready = 1'b0;
  logic [31:0]         imem_addr;
  logic                imem_rsp_valid = 1'b0;
  logic [31:0]         imem_rsp_data = '0;
  logic                inst_valid;
  logic                inst_ready = 1'b0;
  logic [31:0]         inst;
  logic [31:0]         inst_pc;
  logic                inst_fault;
  logic [C_PERF_W-1:0] perf_wait_cyc;

  ifu_fetch #(.PERF_W(C_PERF_W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .pc_stall(pc_stall), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .perf_wait_cyc(perf_wait_cyc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: a fetch in flight (accepted or not, doomed or not)
  // or a word held for decode.
  bit          m_busy, m_acc, m_doom, m_held, m_fault;
  logic [31:0] m_pc, m_addr, m_word, m_ipc;
  int          m_perf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0297;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_doom = 0; m_held = 0; m_fault = 0;
    m_pc = '0; m_addr = '0; m_word = C_NOP; m_ipc = C_RSTPC; m_perf = 0;
  endtask

  task automatic step(input logic rn, input logic pv, input logic [31:0] p,
                      input logic fl, input logic ir, input logic qr, input logic rg);
    bit rsp_now;
    rst = rn; pc_valid = pv; pc = p; flush = fl; inst_ready = ir; imem_req_ready = qr;
    rsp_now = rn && m_busy && m_acc && rg;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(m_addr) : $urandom;
    #1;
    chk("pc_stall", {31'b0, pc_stall}, {31'b0, (!rn || !(m_held && ir && !fl))});
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else if (m_held) begin
      if (fl || ir) m_held = 0;
    end else if (m_busy) begin
      if (!m_acc) begin
        if (fl) m_doom = 1;
        if (qr) m_acc = 1;
      end else begin
        m_perf = (m_perf < C_PMAX) ? m_perf + 1 : C_PMAX;
        if (rsp_now) begin
          m_busy = 0;
          if (!(m_doom || fl)) begin
            m_held = 1; m_word = mem_word(m_addr); m_ipc = m_pc; m_fault = 0;
          end
        end else if (fl) begin
          m_doom = 1;
        end
      end
    end else if (pv && !fl) begin
`ifdef IFU_MISALIGN_CHK_EN
      if (p[1:0] != 2'b00) begin
        m_held = 1; m_word = C_NOP; m_ipc = p; m_fault = 1;
      end else
`endif
      begin
        m_busy = 1; m_acc = 0; m_doom = 0; m_pc = p; m_addr = {p[31:2], 2'b00};
      end
    end
    #1;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, (m_busy && !m_acc)});
    if (m_busy && !m_acc) chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_held});
    chk("inst", inst, m_held ? m_word : C_NOP);
    if (m_held) chk("inst_pc", inst_pc, m_ipc);
    if (m_held) chk("inst_fault", {31'b0, inst_fault}, {31'b0, m_fault});
    chk("perf", {{(32-C_PERF_W){1'b0}}, perf_wait_cyc}, m_perf);
    if (!rn) begin
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_inst_pc", inst_pc, C_RSTPC);
      chk("rst_fault", {31'b0, inst_fault}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] rp;
    model_reset();
    // Reset held for two cycles.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Zero-wait fetch of the reset PC with decode always ready.
    step(1, 1, 32'h8000_0000, 0, 1, 1, 1);
    repeat (4) step(1, 0, 0, 0, 1, 1, 1);
    // Backpressure on memory request and on decode.
    step(1, 1, 32'h8000_0004, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    // Flush in WAIT; late response is dropped, then a clean fetch.
    step(1, 1, 32'h8000_0008, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'h8000_0010, 0, 1, 1, 1);
    repeat (4) step(1, 0, 0, 0, 1, 1, 1);
    // Flush together with inst_ready in HOLD.
    step(1, 1, 32'h8000_0020, 0, 0, 1, 1);
    repeat (2) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Misaligned PC.
    step(1, 1, 32'h8000_0002, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0, 0);
    // Flush in same cycle as the response.
    step(1, 1, 32'h8000_0030, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with occasional mid-operation reset.
    for (int i = 0; i < 4000; i++) begin
      rp = $urandom;
      if ($urandom_range(7) != 0) rp[1:0] = 2'b00;
      step(($urandom_range(149) != 0),
           ($urandom_range(9) < 7), rp,
           ($urandom_range(11) == 0),
           ($urandom_range(1) == 0),
           ($urandom_range(9) < 6),
           ($urandom_range(9) < 4));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
